fpu_mul_arbiter: RTL

//  Shares one combinational double-precision multiplier (fpu_dp_multiplier) between
//  NUM_REQ requesters. Grants in round-robin order and registers the winner's operands

---
 rtl/fpu_mul_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one combinational double-precision multiplier between
// NUM_REQ requesters; one operation in flight, product returned over valid/ready.
module fpu_mul_arbiter #(
    parameter  int WIDTH   = 64,
    parameter  int NUM_REQ = 4,
    parameter  int MUL_LAT = 2,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [WIDTH-1:0]         mul_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     busy
);

    localparam int               CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [ID_W:0]    NREQ     = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic [ID_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [WIDTH-1:0]               mul_a_q, mul_a_d;
    logic [WIDTH-1:0]               mul_b_q, mul_b_d;
    logic [ID_W-1:0]                rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]               rsp_result_q, rsp_result_d;

    logic [NUM_REQ-1:0][WIDTH-1:0]  a_arr, b_arr;
    logic                           grant_vld;
    logic [ID_W-1:0]                grant_id;
    logic [ID_W:0]                  cand;

    assign a_arr = req_a;
    assign b_arr = req_b;

    // Cyclic search starting at rr_ptr; cand is wrapped explicitly so non-power-of-2
    // NUM_REQ works.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= NREQ) cand = cand - NREQ;
            if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        req_ready    = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    req_ready = NUM_REQ'(1) << grant_id;
                    mul_a_d   = a_arr[grant_id];
                    mul_b_d   = b_arr[grant_id];
                    rsp_id_d  = grant_id;
                    rr_ptr_d  = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                    cnt_d     = CNT_INIT;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_result_d = mul_result;
                    state_d      = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);

endmodule
